// File: rtl/read_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// read_dispatcher_pkg
//   Shared definitions for the SRAM read-side dispatcher.
//   - beat_kind_e : kind of beat held in the registered output stage
//   - state_e     : dispatcher FSM states
//   - PortIdWidth : width of the destination-port field in the packet header.
//                   The write path builds headers with the same field width.
//   - port_in_range : true when a header port field addresses a real port
// ---------------------------------------------------------------------------
package read_dispatcher_pkg;

    localparam int unsigned PortIdWidth = 4;

    typedef enum logic [1:0] {
        KindSop = 2'd0,
        KindVld = 2'd1,
        KindEop = 2'd2
    } beat_kind_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHdr     = 3'd1,
        StEmitSop = 3'd2,
        StEmitHdr = 3'd3,
        StFwd     = 3'd4,
        StDrop    = 3'd5
    } state_e;

    // Header port fields are zero-extended to 32 bits by the caller so the
    // check works for any port-field width.
    function automatic logic port_in_range(input logic [31:0] port, input int unsigned num_ports);
        return port < num_ports;
    endfunction

endpackage

// File: rtl/rd_out_stage.sv
// ---------------------------------------------------------------------------
// rd_out_stage
//   Single registered output beat (obuf) shared by all egress ports, plus the
//   per-port demux of the held beat.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     load              write a new beat into obuf (honoured only when free)
//     load_kind/port/data  contents of the beat being loaded
//     port_ready        per-port "take the pending beat" strobe
//     obuf_free         obuf is empty or its beat is taken this cycle
//     obuf_valid        obuf holds a beat
//     sop/eop/vld       per-port beat markers, only on the addressed port
//     out_data          packed per-port data; only the addressed slice is
//                       non-zero
// ---------------------------------------------------------------------------
module rd_out_stage
    import read_dispatcher_pkg::*;
#(
    parameter int unsigned num_of_ports    = 16,
    parameter int unsigned fifo_data_width = 64,
    parameter int unsigned port_id_width   = PortIdWidth
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load,
    input  beat_kind_e                              load_kind,
    input  logic [port_id_width-1:0]                load_port,
    input  logic [fifo_data_width-1:0]              load_data,
    input  logic [num_of_ports-1:0]                 port_ready,
    output logic                                    obuf_free,
    output logic                                    obuf_valid,
    output logic [num_of_ports-1:0]                 sop,
    output logic [num_of_ports-1:0]                 eop,
    output logic [num_of_ports-1:0]                 vld,
    output logic [fifo_data_width*num_of_ports-1:0] out_data
);

    logic                       obuf_valid_q;
    beat_kind_e                 obuf_kind_q;
    logic [port_id_width-1:0]   obuf_port_q;
    logic [fifo_data_width-1:0] obuf_data_q;
    logic                       sel_ready;

    // The held beat only changes once it has been taken (or obuf was empty),
    // so a stalled port always sees a stable beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            obuf_valid_q <= 1'b0;
            obuf_kind_q  <= KindSop;
            obuf_port_q  <= '0;
            obuf_data_q  <= '0;
        end else if (obuf_free) begin
            obuf_valid_q <= load;
            if (load) begin
                obuf_kind_q <= load_kind;
                obuf_port_q <= load_port;
                obuf_data_q <= load_data;
            end
        end
    end

    // Demux by comparison rather than direct indexing so that port ids that
    // do not map to a port never index out of range.
    always_comb begin
        sel_ready = 1'b0;
        sop       = '0;
        eop       = '0;
        vld       = '0;
        out_data  = '0;
        for (int unsigned p = 0; p < num_of_ports; p++) begin
            if (obuf_port_q == port_id_width'(p)) begin
                sel_ready = port_ready[p];
                if (obuf_valid_q) begin
                    sop[p] = (obuf_kind_q == KindSop);
                    vld[p] = (obuf_kind_q == KindVld);
                    eop[p] = (obuf_kind_q == KindEop);
                    out_data[p*fifo_data_width +: fifo_data_width] = obuf_data_q;
                end
            end
        end
    end

    assign obuf_free  = !obuf_valid_q || sel_ready;
    assign obuf_valid = obuf_valid_q;

endmodule

// File: rtl/read_dispatcher.sv
// ---------------------------------------------------------------------------
// read_dispatcher
//   Takes one framed packet stream read back from SRAM (sop marker, header
//   beat, data beats, eop marker) and delivers each packet to the egress port
//   named in the low bits of its header, with the same framing per port.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     in_sop/vld/eop    input beat markers (priority eop > sop > vld)
//     in_data           input beat data
//     in_ready          input beat is accepted this cycle
//     port_ready        per-port backpressure for the output stage
//     sop/eop/vld       per-port output beat markers
//     out_data          packed per-port output data, slice p = [(p+1)*W-1:p*W]
//     busy              a packet is in flight or a beat is still held
//     drop_err          one-cycle pulse, registered, when a packet is discarded
// ---------------------------------------------------------------------------
module read_dispatcher
    import read_dispatcher_pkg::*;
#(
    parameter int unsigned num_of_ports    = 16,
    parameter int unsigned fifo_data_width = 64,
    parameter int unsigned port_id_width   = PortIdWidth
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_sop,
    input  logic                                    in_vld,
    input  logic                                    in_eop,
    input  logic [fifo_data_width-1:0]              in_data,
    output logic                                    in_ready,
    input  logic [num_of_ports-1:0]                 port_ready,
    output logic [num_of_ports-1:0]                 sop,
    output logic [num_of_ports-1:0]                 eop,
    output logic [num_of_ports-1:0]                 vld,
    output logic [fifo_data_width*num_of_ports-1:0] out_data,
    output logic                                    busy,
    output logic                                    drop_err
);

    state_e                     state_q, state_d;
    logic [port_id_width-1:0]   dest_q, dest_d;
    logic [fifo_data_width-1:0] hdr_word_q, hdr_word_d;
    logic                       drop_err_q, drop_event;

    logic                       obuf_free;
    logic                       obuf_valid;
    logic                       load;
    beat_kind_e                 load_kind;
    logic [fifo_data_width-1:0] load_data;

    logic                       accept;
    logic [port_id_width-1:0]   hdr_port;

    assign accept   = in_ready && (in_sop || in_vld || in_eop);
    assign hdr_port = in_data[port_id_width-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dest_q     <= '0;
            hdr_word_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            hdr_word_q <= hdr_word_d;
            drop_err_q <= drop_event;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        hdr_word_d = hdr_word_q;
        drop_event = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Stray vld/eop beats are swallowed here.
                if (accept && !in_eop && in_sop) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    if (in_eop) begin
                        // sop immediately followed by eop: nothing to deliver.
                        drop_event = 1'b1;
                        state_d    = StIdle;
                    end else if (!in_sop && in_vld) begin
                        dest_d     = hdr_port;
                        hdr_word_d = in_data;
                        if (port_in_range(32'(hdr_port), num_of_ports)) begin
                            state_d = StEmitSop;
                        end else begin
                            drop_event = 1'b1;
                            state_d    = StDrop;
                        end
                    end
                end
            end
            StEmitSop: begin
                // Waiting for obuf_free also keeps a new packet from overtaking
                // the previous packet's eop.
                if (obuf_free) begin
                    state_d = StEmitHdr;
                end
            end
            StEmitHdr: begin
                if (obuf_free) begin
                    state_d = StFwd;
                end
            end
            StFwd: begin
                if (accept && in_eop) begin
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (accept && in_eop) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        load      = 1'b0;
        load_kind = KindVld;
        load_data = '0;
        if (!rst) begin
            unique case (state_q)
                StIdle, StHdr, StDrop: begin
                    in_ready = 1'b1;
                end
                StEmitSop: begin
                    load      = obuf_free;
                    load_kind = KindSop;
                end
                StEmitHdr: begin
                    load      = obuf_free;
                    load_kind = KindVld;
                    load_data = hdr_word_q;
                end
                StFwd: begin
                    // A beat is only taken when obuf can absorb it this cycle.
                    in_ready = obuf_free;
                    if (obuf_free && in_eop) begin
                        load      = 1'b1;
                        load_kind = KindEop;
                    end else if (obuf_free && !in_sop && in_vld) begin
                        load      = 1'b1;
                        load_kind = KindVld;
                        load_data = in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    rd_out_stage #(
        .num_of_ports   (num_of_ports),
        .fifo_data_width(fifo_data_width),
        .port_id_width  (port_id_width)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_kind (load_kind),
        .load_port (dest_q),
        .load_data (load_data),
        .port_ready(port_ready),
        .obuf_free (obuf_free),
        .obuf_valid(obuf_valid),
        .sop       (sop),
        .eop       (eop),
        .vld       (vld),
        .out_data  (out_data)
    );

    assign busy     = (state_q != StIdle) || obuf_valid;
    assign drop_err = drop_err_q;

endmodule
